// File: rtl/nr_flow_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nr_flow_pkg
// Description : Shared state encoding and condition-flag indices for the
//               nanoRisk flow-control unit.
// Revision    : 1.0
// ============================================================================
package nr_flow_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REDIR = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam int COND_Z = 0;
    localparam int COND_N = 1;
    localparam int COND_C = 2;
    localparam int COND_V = 3;

endpackage
`default_nettype wire

// File: rtl/nr_cond_eval.sv
`default_nettype none
// ============================================================================
// Module      : nr_cond_eval
// Description : Condition flag mux with optional inversion; an out-of-range
//               selector always evaluates false.
// Revision    : 1.0
// ============================================================================
module nr_cond_eval
    import nr_flow_pkg::*;
#(
    parameter int N_COND = 4
) (
    input  logic [$clog2(N_COND)-1:0] cond_sel,
    input  logic                      cond_inv,
    input  logic [N_COND-1:0]         flags,
    output logic                      cond_true
);

    localparam int SEL_W = $clog2(N_COND);

    logic w_sel_flag;
    logic w_in_range;

    // Loop-based mux so selector codes with no matching flag fall through as false.
    always_comb begin
        w_sel_flag = 1'b0;
        w_in_range = 1'b0;
        for (int i = 0; i < N_COND; i++) begin
            if (cond_sel == SEL_W'(i)) begin
                w_sel_flag = flags[i];
                w_in_range = 1'b1;
            end
        end
        cond_true = w_in_range & (w_sel_flag ^ cond_inv);
    end

endmodule
`default_nettype wire

// File: rtl/nr_flow_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module      : nr_flow_ctrl_unit
// Description : Registered branch/jump redirect with a programmable flush
//               window and a saturating taken-redirect counter.
// Revision    : 1.0
// ============================================================================
module nr_flow_ctrl_unit
    import nr_flow_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int N_COND       = 4,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall,
    input  logic                      branch,
    input  logic                      jump,
    input  logic [$clog2(N_COND)-1:0] cond_sel,
    input  logic                      cond_inv,
    input  logic [N_COND-1:0]         flags,
    input  logic [ADDR_W-1:0]         target,
    output logic                      redirect,
    output logic [ADDR_W-1:0]         redirect_addr,
    output logic                      flush,
    output logic                      busy,
    output logic [CNT_W-1:0]          taken_cnt
);

    localparam int FCNT_W = $clog2(FLUSH_CYCLES) + 1;
    localparam logic [FCNT_W-1:0] FCNT_INIT =
        (FLUSH_CYCLES > 1) ? FCNT_W'(FLUSH_CYCLES - 2) : '0;

    state_t              r_state;
    state_t              w_state_next;
    logic [FCNT_W-1:0]   r_fcnt;
    logic [FCNT_W-1:0]   w_fcnt_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [CNT_W-1:0]    r_cnt;
    logic                w_cond_true;
    logic                w_taken;
    logic                w_accept;

    nr_cond_eval #(
        .N_COND (N_COND)
    ) u_cond_eval (
        .cond_sel  (cond_sel),
        .cond_inv  (cond_inv),
        .flags     (flags),
        .cond_true (w_cond_true)
    );

    assign w_taken  = jump | (branch & w_cond_true);
    assign w_accept = (r_state == IDLE) && !stall && w_taken;

    always_comb begin
        w_state_next = r_state;
        w_fcnt_next  = r_fcnt;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = REDIR;
                end
            end
            REDIR: begin
                if (!stall) begin
                    if (FLUSH_CYCLES > 1) begin
                        w_state_next = FLUSH;
                        w_fcnt_next  = FCNT_INIT;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            FLUSH: begin
                if (!stall) begin
                    if (r_fcnt == '0) begin
                        w_state_next = IDLE;
                    end else begin
                        w_fcnt_next = r_fcnt - 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_fcnt  <= '0;
            r_addr  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_fcnt  <= w_fcnt_next;
            if (w_accept) begin
                r_addr <= target;
                if (r_cnt != '1) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    // Control outputs come straight from the state register: no input-to-output path.
    assign redirect      = (r_state == REDIR);
    assign flush         = (r_state == REDIR) || (r_state == FLUSH);
    assign busy          = (r_state != IDLE);
    assign redirect_addr = r_addr;
    assign taken_cnt     = r_cnt;

endmodule
`default_nettype wire

// File: doc/nr_flow_ctrl_unit.md
Name: nr_flow_ctrl_unit

Overview:
Sequential, parametrised successor to the nanoRisk combinational branch/jump OR. It evaluates conditional branches against a selectable flag set and registers the redirect target. It then issues a one-cycle-latency PC redirect, held until the pipeline accepts it, followed by a programmable flush window. It also keeps a saturating count of taken redirects. It sits between the decode/control stage and the PC-select mux.

Parameters:
ADDR_W, 8, width of PC/target addresses
N_COND, 4, number of condition flags selectable by cond_sel (>=2)
FLUSH_CYCLES, 2, total cycles flush is asserted per redirect, REDIR cycle included (>=1)
CNT_W, 16, width of taken-redirect statistics counter

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
stall  input  1  pipeline not advancing; in IDLE, ignore requests; in REDIR/FLUSH, freeze state
branch  input  1  conditional branch request from control
jump  input  1  unconditional jump request from control
cond_sel  input  $clog2(N_COND)  index of flag tested by branch
cond_inv  input  1  1 = branch when selected flag is 0
flags  input  N_COND  condition flags (Z,N,C,V order for N_COND=4)
target  input  ADDR_W  branch/jump destination
redirect  output  1  PC mux select: take redirect_addr
redirect_addr  output  ADDR_W  registered target
flush  output  1  squash younger instructions
busy  output  1  state != IDLE
taken_cnt  output  CNT_W  saturating count of accepted redirects

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous and active-high.
- Reset: state=IDLE; redirect=0, redirect_addr=0, flush=0, busy=0, taken_cnt=0. Reset asserted in any state, including mid-FLUSH, wins at the next edge.
- Taken decision (combinational, IDLE only): taken = jump | (branch & (flags[cond_sel] ^ cond_inv)).
  - cond_sel >= N_COND: condition is false.
  - branch and jump together: jump has priority, so the request is taken regardless of the flags.
- States: IDLE, REDIR, FLUSH.
- IDLE:
  - If stall=0 and taken at the edge ending cycle T: redirect_addr<=target, taken_cnt += 1 (saturating at all-ones), next state REDIR.
  - If stall=1: branch and jump are ignored, nothing is captured.
- REDIR (cycle T+1 onward): redirect=1, flush=1.
  - stall=1: hold REDIR, with redirect_addr and outputs stable.
  - stall=0: go to FLUSH with cnt=FLUSH_CYCLES-2 if FLUSH_CYCLES>1, else go to IDLE.
- FLUSH: redirect=0, flush=1.
  - stall=1 freezes cnt.
  - Otherwise, cnt==0 goes to IDLE, else cnt decrements.
- Latency: redirect visible exactly 1 cycle after an accepted request. Total flush assertion is FLUSH_CYCLES unstalled cycles.
- branch and jump are ignored in REDIR and FLUSH, since they come from squashed instructions. A new request is accepted in the first IDLE cycle, with no dead cycle beyond FLUSH.
- Outputs redirect, flush and busy are decoded from state registers only; they are glitch-free with no input-to-output combinational path.
- Width: target is captured full-width with no truncation. Flush counter width is $clog2(FLUSH_CYCLES)+1.

Decomposition:
- Shared package nr_flow_pkg:
  - state enum {IDLE, REDIR, FLUSH}
  - flag index constants COND_Z=0, COND_N=1, COND_C=2, COND_V=3
- Sub-module nr_cond_eval: combinational flag mux + inversion + range check, outputting cond_true. The FSM, capture registers and counter stay in the top module.

Test Plan:
1. Jump in IDLE, stall=0, target=8'h3C, FLUSH_CYCLES=2 -> cycle T+1: redirect=1, redirect_addr=3C, flush=1; T+2: redirect=0, flush=1; T+3: busy=0; taken_cnt=1.
2. branch=1, cond_sel=0, flags=4'b0001 with cond_inv=0, then again with cond_inv=1 -> first is taken (redirect_addr=target); second has no redirect and taken_cnt is unchanged.
3. Redirect with stall=1 for 3 cycles during REDIR -> redirect=1, redirect_addr stable for 4 cycles. FLUSH then lasts 1 cycle after stall drops; branch pulses during REDIR/FLUSH are not taken.
4. branch=jump=1, flags=0, cond_sel=5 (N_COND=8) -> taken via jump. branch alone with cond_sel=5 -> not taken.
5. CNT_W=4: 17 back-to-back redirects -> taken_cnt reaches 4'hF and stays there. rst=1 during FLUSH -> next cycle all outputs 0, state IDLE.
6. FLUSH_CYCLES=1: jump -> single cycle with redirect=1 and flush=1, then IDLE. A jump in the following cycle is accepted.
